// File: rtl/sample_irq_scheduler_if.sv
// Bus bundle for sample_irq_scheduler: sample stream in, host readout and interrupt out.
// Sample handshake: a word on s_data transfers on a clock edge where s_valid && s_ready are both high;
// s_valid does not wait for s_ready, and a word offered while s_ready is low is not taken.
interface sample_irq_scheduler_if #(
  parameter int LEVEL_W = 5
);
  logic               enable;
  logic               s_valid;
  logic [15:0]        s_data;
  logic               s_ready;
  logic               rd_en;
  logic [15:0]        rd_data;
  logic               rd_valid;
  logic [LEVEL_W-1:0] level;
  logic               irq;
  logic               irq_ack;
  logic               overflow;
  logic               clr_ovf;
  logic [1:0]         state;

  modport master (
    output enable, s_valid, s_data, rd_en, irq_ack, clr_ovf,
    input  s_ready, rd_data, rd_valid, level, irq, overflow, state
  );

  modport slave (
    input  enable, s_valid, s_data, rd_en, irq_ack, clr_ovf,
    output s_ready, rd_data, rd_valid, level, irq, overflow, state
  );
endinterface

// File: rtl/sample_irq_scheduler.sv
// Sample FIFO with threshold/timeout interrupt scheduling and a registered host read port.
// state exposes the scheduler FSM (0=IDLE, 1=ASSERT, 2=SERVICE).
module sample_irq_scheduler #(
  parameter int DEPTH          = 16,
  parameter int THRESH         = 8,
  parameter int TIMEOUT_CYCLES = 10_000_000
) (
  input logic                   clk,
  input logic                   rstn,
  sample_irq_scheduler_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  localparam logic [LW-1:0] DEPTH_L  = LW'(DEPTH);
  localparam logic [LW-1:0] THRESH_L = LW'(THRESH);
  localparam logic [AW:0]   PTR_ONE  = (AW+1)'(1);
  localparam logic [TW-1:0] TMR_ONE  = TW'(1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t state, next_state;

  logic [15:0]   mem [DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic [LW-1:0] level;
  logic          full, s_ready, wr_acc, rd_acc, ovf_set;
  logic [15:0]   rd_data;
  logic          rd_valid, overflow, irq;
  logic [TW-1:0] timer;
  logic          busy_q, timer_run;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign level   = wr_ptr - rd_ptr;
  assign full    = (level == DEPTH_L);
  assign s_ready = bus.enable && !full;
  assign wr_acc  = bus.s_valid && s_ready;
  assign rd_acc  = bus.rd_en && (level != '0);
  assign ovf_set = bus.enable && bus.s_valid && !s_ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_acc) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr[AW-1:0]] <= bus.s_data;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_data  <= 16'h0000;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_acc;
      if (rd_acc) rd_data <= mem[rd_ptr[AW-1:0]];
    end
  end

  // A set in the same cycle as clr_ovf wins so no drop is ever lost.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      overflow <= 1'b0;
    end else if (ovf_set) begin
      overflow <= 1'b1;
    end else if (bus.clr_ovf) begin
      overflow <= 1'b0;
    end
  end

  // The timer starts on the first full cycle the FIFO has been seen non-empty,
  // giving TIMEOUT_CYCLES+1 cycles from the first accepted sample to irq.
  assign timer_run = bus.enable && (state == IDLE) && (next_state == IDLE) && (level != '0);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      busy_q <= 1'b0;
      timer  <= '0;
    end else begin
      busy_q <= (level != '0);
      timer  <= (timer_run && busy_q) ? timer + TMR_ONE : '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (!bus.enable) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:    if (level >= THRESH_L || timer == TMO_LAST) next_state = ASSERT;
        ASSERT:  if (bus.irq_ack) next_state = SERVICE;
        SERVICE: if (level == '0) next_state = IDLE;
        default: next_state = IDLE;
      endcase
    end
  end

  // irq is registered alongside the state so it is high exactly while in ASSERT.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) irq <= 1'b0;
    else       irq <= (next_state == ASSERT);
  end

  assign bus.s_ready  = s_ready;
  assign bus.rd_data  = rd_data;
  assign bus.rd_valid = rd_valid;
  assign bus.level    = level;
  assign bus.irq      = irq;
  assign bus.overflow = overflow;
  assign bus.state    = state;
endmodule

// File: tb/tb_sample_irq_scheduler.sv
// Directed bench for sample_irq_scheduler (DEPTH=8, THRESH=4, TIMEOUT_CYCLES=20).
module tb_sample_irq_scheduler;
  localparam int DEPTH  = 8;
  localparam int THRESH = 4;
  localparam int TMO    = 20;
  localparam int LW     = 4;

  logic clk  = 1'b0;
  logic rstn = 1'b1;

  always #5 clk = ~clk;

  sample_irq_scheduler_if #(.LEVEL_W(LW)) bus ();

  sample_irq_scheduler #(
    .DEPTH(DEPTH),
    .THRESH(THRESH),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .bus(bus)
  );

  typedef struct {
    logic        en, sv;
    logic [15:0] sd;
    logic        rd, ack, clr;
    logic [3:0]  lvl;
    logic        srdy, rdv;
    logic [15:0] rdd;
    logic        irq, ovf;
    logic [1:0]  st;
  } vec_t;

  vec_t        vecs[$];
  logic [15:0] exp_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;

  function automatic vec_t mk(input logic en, input logic sv, input logic [15:0] sd,
                              input logic rd, input logic ack, input logic clr,
                              input logic [3:0] lvl, input logic srdy, input logic rdv,
                              input logic [15:0] rdd, input logic irq, input logic ovf,
                              input logic [1:0] st);
    vec_t v;
    v.en = en; v.sv = sv; v.sd = sd; v.rd = rd; v.ack = ack; v.clr = clr;
    v.lvl = lvl; v.srdy = srdy; v.rdv = rdv; v.rdd = rdd; v.irq = irq; v.ovf = ovf; v.st = st;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Drive one cycle of inputs, then sample 1ns after the rising edge.
  task automatic cyc(input logic en, input logic sv, input logic [15:0] sd,
                     input logic rd, input logic ack, input logic clr);
    bus.enable  = en;
    bus.s_valid = sv;
    bus.s_data  = sd;
    bus.rd_en   = rd;
    bus.irq_ack = ack;
    bus.clr_ovf = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic check_vec(input int i, input vec_t v);
    check($sformatf("vec%0d_level", i),    32'(bus.level),    32'(v.lvl));
    check($sformatf("vec%0d_s_ready", i),  32'(bus.s_ready),  32'(v.srdy));
    check($sformatf("vec%0d_rd_valid", i), 32'(bus.rd_valid), 32'(v.rdv));
    check($sformatf("vec%0d_rd_data", i),  32'(bus.rd_data),  32'(v.rdd));
    check($sformatf("vec%0d_irq", i),      32'(bus.irq),      32'(v.irq));
    check($sformatf("vec%0d_overflow", i), 32'(bus.overflow), 32'(v.ovf));
    check($sformatf("vec%0d_state", i),    32'(bus.state),    32'(v.st));
  endtask

  initial begin : main
    int n;
    logic [15:0] w;

    // Threshold irq, ack, drain, empty read, stray ack
    vecs.push_back(mk(1,1,16'h0001,0,0,0, 1,1,0,16'h0000,0,0,0));
    vecs.push_back(mk(1,1,16'h0002,0,0,0, 2,1,0,16'h0000,0,0,0));
    vecs.push_back(mk(1,1,16'h0003,0,0,0, 3,1,0,16'h0000,0,0,0));
    vecs.push_back(mk(1,1,16'h0004,0,0,0, 4,1,0,16'h0000,0,0,0));
    vecs.push_back(mk(1,0,16'h0000,0,0,0, 4,1,0,16'h0000,1,0,1));
    vecs.push_back(mk(1,0,16'h0000,0,0,0, 4,1,0,16'h0000,1,0,1));
    vecs.push_back(mk(1,0,16'h0000,0,1,0, 4,1,0,16'h0000,0,0,2));
    vecs.push_back(mk(1,0,16'h0000,1,0,0, 3,1,1,16'h0001,0,0,2));
    vecs.push_back(mk(1,0,16'h0000,1,0,0, 2,1,1,16'h0002,0,0,2));
    vecs.push_back(mk(1,0,16'h0000,1,0,0, 1,1,1,16'h0003,0,0,2));
    vecs.push_back(mk(1,0,16'h0000,1,0,0, 0,1,1,16'h0004,0,0,2));
    vecs.push_back(mk(1,0,16'h0000,0,0,0, 0,1,0,16'h0004,0,0,0));
    vecs.push_back(mk(1,0,16'h0000,1,0,0, 0,1,0,16'h0004,0,0,0));
    vecs.push_back(mk(1,0,16'h0000,0,1,0, 0,1,0,16'h0004,0,0,0));
    // Fill to full, drop, overflow set/clear and set-beats-clear
    vecs.push_back(mk(1,1,16'h0010,0,0,0, 1,1,0,16'h0004,0,0,0));
    vecs.push_back(mk(1,1,16'h0011,0,0,0, 2,1,0,16'h0004,0,0,0));
    vecs.push_back(mk(1,1,16'h0012,0,0,0, 3,1,0,16'h0004,0,0,0));
    vecs.push_back(mk(1,1,16'h0013,0,0,0, 4,1,0,16'h0004,0,0,0));
    vecs.push_back(mk(1,1,16'h0014,0,0,0, 5,1,0,16'h0004,1,0,1));
    vecs.push_back(mk(1,1,16'h0015,0,0,0, 6,1,0,16'h0004,1,0,1));
    vecs.push_back(mk(1,1,16'h0016,0,0,0, 7,1,0,16'h0004,1,0,1));
    vecs.push_back(mk(1,1,16'h0017,0,0,0, 8,0,0,16'h0004,1,0,1));
    vecs.push_back(mk(1,1,16'h0018,0,0,0, 8,0,0,16'h0004,1,1,1));
    vecs.push_back(mk(1,0,16'h0000,0,0,1, 8,0,0,16'h0004,1,0,1));
    vecs.push_back(mk(1,1,16'h0019,0,0,1, 8,0,0,16'h0004,1,1,1));
    vecs.push_back(mk(1,0,16'h0000,0,0,1, 8,0,0,16'h0004,1,0,1));
    vecs.push_back(mk(1,0,16'h0000,0,1,0, 8,0,0,16'h0004,0,0,2));

    // Clock/reset
    bus.enable = 0; bus.s_valid = 0; bus.s_data = '0;
    bus.rd_en = 0; bus.irq_ack = 0; bus.clr_ovf = 0;
    #2 rstn = 1'b0;
    #1;
    check("reset_level",    32'(bus.level),    0);
    check("reset_irq",      32'(bus.irq),      0);
    check("reset_rd_valid", 32'(bus.rd_valid), 0);
    check("reset_overflow", 32'(bus.overflow), 0);
    check("reset_rd_data",  32'(bus.rd_data),  0);
    check("reset_state",    32'(bus.state),    0);
    @(posedge clk); @(posedge clk); #1;
    rstn = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      cyc(vecs[i].en, vecs[i].sv, vecs[i].sd, vecs[i].rd, vecs[i].ack, vecs[i].clr);
      check_vec(i, vecs[i]);
    end

    // Drain the full FIFO: dropped words 0x18/0x19 must not appear
    for (int i = 0; i < DEPTH; i++) begin
      cyc(1, 0, 16'h0, 1, 0, 0);
      check($sformatf("drain%0d_rd_data", i), 32'(bus.rd_data),  32'(16'h0010 + i));
      check($sformatf("drain%0d_rd_valid", i), 32'(bus.rd_valid), 1);
      check($sformatf("drain%0d_level", i),   32'(bus.level),    32'(DEPTH - 1 - i));
    end
    cyc(1, 0, 16'h0, 0, 0, 0);
    check("drain_state_idle", 32'(bus.state), 0);

    // Timeout irq: one sample, then wait with a bounded budget
    cyc(1, 1, 16'hA5A5, 0, 0, 0);
    check("tmo_level1", 32'(bus.level), 1);
    n = 0;
    while (!bus.irq && n < 60) begin
      cyc(1, 0, 16'h0, 0, 0, 0);
      n++;
    end
    check("tmo_latency", 32'(n), 32'(TMO + 1));
    cyc(1, 0, 16'h0, 0, 1, 0);
    check("tmo_ack_irq", 32'(bus.irq), 0);
    cyc(1, 0, 16'h0, 1, 0, 0);
    check("tmo_rd_data",  32'(bus.rd_data),  32'h0000A5A5);
    check("tmo_rd_valid", 32'(bus.rd_valid), 1);
    check("tmo_level0",   32'(bus.level),    0);
    cyc(1, 0, 16'h0, 0, 0, 0);
    check("tmo_state_idle", 32'(bus.state), 0);

    // Simultaneous read/write at level 3 across pointer wrap
    for (int i = 0; i < 3; i++) begin
      w = 16'h0100 + 16'(i);
      cyc(1, 1, w, 0, 0, 0);
      exp_q.push_back(w);
    end
    check("wrap_level3", 32'(bus.level), 3);
    for (int i = 0; i < 20; i++) begin
      w = 16'h0103 + 16'(i);
      cyc(1, 1, w, 1, 0, 0);
      exp_q.push_back(w);
      check($sformatf("wrap%0d_rd_data", i), 32'(bus.rd_data), 32'(exp_q.pop_front()));
      check($sformatf("wrap%0d_level", i),   32'(bus.level),   3);
    end
    check("wrap_timeout_irq", 32'(bus.irq), 1);
    cyc(1, 0, 16'h0, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 16'h0, 1, 0, 0);
      check($sformatf("wrap_tail%0d_rd_data", i), 32'(bus.rd_data), 32'(exp_q.pop_front()));
    end
    cyc(1, 0, 16'h0, 0, 0, 0);
    check("wrap_end_level", 32'(bus.level), 0);
    check("wrap_end_state", 32'(bus.state), 0);

    // Disable during ASSERT
    for (int i = 0; i < THRESH; i++) cyc(1, 1, 16'h0030 + 16'(i), 0, 0, 0);
    cyc(1, 0, 16'h0, 0, 0, 0);
    check("dis_irq_before", 32'(bus.irq), 1);
    cyc(0, 0, 16'h0, 0, 0, 0);
    check("dis_irq",     32'(bus.irq),     0);
    check("dis_s_ready", 32'(bus.s_ready), 0);
    check("dis_state",   32'(bus.state),   0);
    check("dis_level",   32'(bus.level),   4);
    cyc(1, 0, 16'h0, 0, 0, 0);
    check("reen_irq", 32'(bus.irq), 1);
    cyc(1, 0, 16'h0, 0, 1, 0);
    check("reen_service", 32'(bus.state), 2);

    // Reset mid-SERVICE with level 5
    cyc(1, 1, 16'h0034, 0, 0, 0);
    cyc(1, 1, 16'h0035, 1, 0, 0);
    check("pre_rst_level",    32'(bus.level),    5);
    check("pre_rst_rd_valid", 32'(bus.rd_valid), 1);
    #2 rstn = 1'b0;
    #1;
    check("mid_rst_level",    32'(bus.level),    0);
    check("mid_rst_irq",      32'(bus.irq),      0);
    check("mid_rst_rd_valid", 32'(bus.rd_valid), 0);
    check("mid_rst_overflow", 32'(bus.overflow), 0);
    check("mid_rst_rd_data",  32'(bus.rd_data),  0);
    check("mid_rst_state",    32'(bus.state),    0);
    bus.enable = 0; bus.s_valid = 0; bus.rd_en = 0;
    @(posedge clk); #1;
    rstn = 1'b1;
    cyc(1, 1, 16'h0077, 0, 0, 0);
    cyc(1, 0, 16'h0, 1, 0, 0);
    check("post_rst_rd_data", 32'(bus.rd_data), 32'h00000077);
    check("post_rst_level",   32'(bus.level),   0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
